axi_lite_dmem_slave: RTL and testbench
======================================

Name: axi_lite_dmem_slave

Overview:
- AXI4-lite slave data memory: the responder for the core's load/store master port.
- Single-port-per-direction synchronous RAM of 32-bit words. Byte addresses arrive already word-scaled (addr = word_index << 2); byte strobes apply per lane.
- Read and write channels are independent FSMs with one outstanding transaction each.
- Sits between the execute stage's AXI master port and the rest of the data path, in place of the external memory controller.

Parameters:
- ADDR_WIDTH, 16, number of word-address bits; depth = 2**ADDR_WIDTH words.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- AXI_AWVALID  in  1  write address valid
- AXI_AWREADY  out  1  write address ready
- AXI_AWADDR  in  32  byte address
- AXI_AWPROT  in  3  ignored
- AXI_WVALID  in  1  write data valid
- AXI_WREADY  out  1  write data ready
- AXI_WDATA  in  32  write data
- AXI_WSTRB  in  4  byte lane enables
- AXI_BVALID  out  1  write response valid
- AXI_BREADY  in  1  write response ready
- AXI_BRESP  out  2  write response code
- AXI_ARVALID  in  1  read address valid
- AXI_ARREADY  out  1  read address ready
- AXI_ARADDR  in  32  byte address
- AXI_ARPROT  in  3  ignored
- AXI_RVALID  out  1  read data valid
- AXI_RREADY  in  1  read data ready
- AXI_RDATA  out  32  read data
- AXI_RRESP  out  2  read response code

Behaviour:
- Reset (rst_n low at posedge clk):
  - All READY outputs are 0 while rst_n is low. They rise to 1 on the first clock edge with rst_n high.
  - BVALID=0, RVALID=0, RDATA=0, BRESP=2'b00, RRESP=2'b00.
  - Any in-flight transaction is discarded. RAM contents are not reset.
- Word index = addr[ADDR_WIDTH+1:2].
- Address in range iff addr[31:ADDR_WIDTH+2]==0. Out of range: response DECERR (2'b11), write suppressed, RDATA=0.
- Write FSM, states W_IDLE, W_RESP:
  - W_IDLE:
    - AWREADY=1 until an AW handshake, then 0 with the address latched.
    - WREADY=1 until a W handshake, then 0 with data and strobe latched.
    - AW and W may arrive in either order or in the same cycle.
  - Once both are latched (or both handshake in the same cycle, edge T):
    - At edge T+1 the RAM is written: each byte lane i where WSTRB[i]=1 gets WDATA[8i+7:8i]; lanes with strobe 0 are untouched.
    - At the same edge BVALID←1, BRESP set, state←W_RESP.
  - WSTRB=4'b0000: no RAM change, response OKAY.
  - W_RESP:
    - BVALID holds until BVALID&&BREADY, then BVALID←0, both READYs←1, state←W_IDLE.
    - BREADY already high when BVALID rises: response completes in 1 cycle.
- Read FSM, states R_IDLE, R_MEM, R_DATA:
  - R_IDLE: ARREADY=1. On handshake at edge T: latch address, ARREADY←0, state←R_MEM.
  - R_MEM: synchronous RAM read at edge T+1, state←R_DATA.
  - R_DATA: RVALID=1 and RDATA/RRESP valid from T+2. RDATA/RRESP stable while RVALID && !RREADY.
  - On RVALID&&RREADY: RVALID←0, ARREADY←1, state←R_IDLE.
  - Minimum read occupancy is 3 cycles per transaction.
- Read/write collision: the RAM write and the RAM read may occur at the same edge on the same word. The read returns the old data (read-first). A read issued after BVALID is seen returns the new data.
- No ordering between channels beyond the collision rule above.

Optional Feature:
- Macro DMEM_MISALIGN_CHECK_EN.
- Defined: in-range address with addr[1:0]!=0 gets SLVERR (2'b10); write suppressed, RDATA=0. DECERR takes priority over SLVERR.
- Undefined: addr[1:0] are ignored and the access completes as OKAY.

Test Plan:
- Reset, then AW+W same cycle (addr 0x10, data 0xDEADBEEF, strb 4'b1111), BREADY=1 -> BVALID one cycle after handshake, BRESP=00; AR 0x10 -> RVALID 2 cycles after AR handshake, RDATA=0xDEADBEEF.
- W first (0x000000AA, strb 4'b0001), AW 0x10 three cycles later -> WREADY low while waiting; BVALID one cycle after the AW handshake; read 0x10 returns 0xDEADBEAA.
- Read 0x20 with RREADY held low 5 cycles -> RVALID and RDATA stable for all 5 cycles, ARREADY=0 throughout; ARREADY=1 the cycle after the R handshake.
- AR 0x1<<(ADDR_WIDTH+2) and write to the same address -> RRESP=11, RDATA=0, BRESP=11; word 0 unchanged.
- Write 0x12345678 to 0x30 while a read of 0x30 hits R_MEM at the same edge -> read returns the prior value; next read returns 0x12345678.
- rst_n low for 1 cycle while BVALID=1 and a read is in R_MEM -> BVALID=0, RVALID=0, READYs 0 during reset and 1 afterwards; with DMEM_MISALIGN_CHECK_EN, AR 0x31 -> RRESP=10.

Source files
------------

// File: rtl/axi_lite_dmem_slave_if.sv
// AXI4-lite bus bundle for the data-memory slave; master drives requests, slave drives responses.
interface axi_lite_dmem_slave_if;
   logic        AXI_AWVALID;
   logic        AXI_AWREADY;
   logic [31:0] AXI_AWADDR;
   logic [2:0]  AXI_AWPROT;
   logic        AXI_WVALID;
   logic        AXI_WREADY;
   logic [31:0] AXI_WDATA;
   logic [3:0]  AXI_WSTRB;
   logic        AXI_BVALID;
   logic        AXI_BREADY;
   logic [1:0]  AXI_BRESP;
   logic        AXI_ARVALID;
   logic        AXI_ARREADY;
   logic [31:0] AXI_ARADDR;
   logic [2:0]  AXI_ARPROT;
   logic        AXI_RVALID;
   logic        AXI_RREADY;
   logic [31:0] AXI_RDATA;
   logic [1:0]  AXI_RRESP;

   modport master (
      output AXI_AWVALID, AXI_AWADDR, AXI_AWPROT,
      input  AXI_AWREADY,
      output AXI_WVALID, AXI_WDATA, AXI_WSTRB,
      input  AXI_WREADY,
      input  AXI_BVALID, AXI_BRESP,
      output AXI_BREADY,
      output AXI_ARVALID, AXI_ARADDR, AXI_ARPROT,
      input  AXI_ARREADY,
      input  AXI_RVALID, AXI_RDATA, AXI_RRESP,
      output AXI_RREADY
   );

   modport slave (
      input  AXI_AWVALID, AXI_AWADDR, AXI_AWPROT,
      output AXI_AWREADY,
      input  AXI_WVALID, AXI_WDATA, AXI_WSTRB,
      output AXI_WREADY,
      output AXI_BVALID, AXI_BRESP,
      input  AXI_BREADY,
      input  AXI_ARVALID, AXI_ARADDR, AXI_ARPROT,
      output AXI_ARREADY,
      output AXI_RVALID, AXI_RDATA, AXI_RRESP,
      input  AXI_RREADY
   );
endinterface

// File: rtl/axi_lite_dmem_slave.sv
// AXI4-lite data memory slave: independent write/read FSMs over a read-first word RAM.
// Optional macro DMEM_MISALIGN_CHECK_EN: misaligned in-range accesses answer SLVERR.
//
// state  | meaning
// W_IDLE | collecting AW and W (either order); writes RAM once both are latched
// W_RESP | BVALID held until BREADY
// R_IDLE | ARREADY high, waiting for a read address
// R_MEM  | synchronous RAM read of the latched word
// R_DATA | loads RDATA/RRESP, then holds RVALID until RREADY
module axi_lite_dmem_slave #(
   parameter int ADDR_WIDTH = 16
) (
   input logic                 clk,
   input logic                 rst_n,
   axi_lite_dmem_slave_if.slave bus
);

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic { W_IDLE, W_RESP } w_state_t;
   typedef enum logic [1:0] { R_IDLE, R_MEM, R_DATA } r_state_t;

   function automatic logic [1:0] resp_for(input logic [31:0] addr);
      logic [1:0] resp;
      resp = RESP_OKAY;
      if (addr[31:ADDR_WIDTH+2] != '0)
         resp = RESP_DECERR;
`ifdef DMEM_MISALIGN_CHECK_EN
      else if (addr[1:0] != 2'b00)
         resp = RESP_SLVERR;
`endif
      return resp;
   endfunction

   logic [31:0] mem [0:(1<<ADDR_WIDTH)-1];

   w_state_t    w_state, w_state_nxt;
   logic        aw_have, w_have, wr_fire;
   logic [31:0] aw_addr, w_data;
   logic [3:0]  w_strb;
   logic        awready_q, wready_q, bvalid_q;
   logic [1:0]  bresp_q, wr_resp;
   logic        aw_hs, w_hs, b_hs;

   r_state_t    r_state, r_state_nxt;
   logic [31:0] ar_addr, ram_q, rdata_q;
   logic        arready_q, rvalid_q;
   logic [1:0]  rresp_q, rd_resp;
   logic        ar_hs, r_hs;

   assign aw_hs   = bus.AXI_AWVALID && awready_q;
   assign w_hs    = bus.AXI_WVALID && wready_q;
   assign b_hs    = bvalid_q && bus.AXI_BREADY;
   assign ar_hs   = bus.AXI_ARVALID && arready_q;
   assign r_hs    = rvalid_q && bus.AXI_RREADY;
   assign wr_resp = resp_for(aw_addr);
   assign rd_resp = resp_for(ar_addr);

   assign bus.AXI_AWREADY = awready_q;
   assign bus.AXI_WREADY  = wready_q;
   assign bus.AXI_BVALID  = bvalid_q;
   assign bus.AXI_BRESP   = bresp_q;
   assign bus.AXI_ARREADY = arready_q;
   assign bus.AXI_RVALID  = rvalid_q;
   assign bus.AXI_RDATA   = rdata_q;
   assign bus.AXI_RRESP   = rresp_q;

   always_ff @(posedge clk) begin
      if (!rst_n) w_state <= W_IDLE;
      else        w_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = w_state;
      wr_fire     = 1'b0;
      case (w_state)
         W_IDLE: if (aw_have && w_have) begin
            wr_fire     = 1'b1;
            w_state_nxt = W_RESP;
         end
         W_RESP: if (b_hs) w_state_nxt = W_IDLE;
         default: w_state_nxt = W_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         aw_have   <= 1'b0;
         w_have    <= 1'b0;
         aw_addr   <= '0;
         w_data    <= '0;
         w_strb    <= '0;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         bresp_q   <= RESP_OKAY;
      end else begin
         if (aw_hs) begin
            aw_addr   <= bus.AXI_AWADDR;
            aw_have   <= 1'b1;
            awready_q <= 1'b0;
         end else if (w_state == W_IDLE && !aw_have) begin
            awready_q <= 1'b1;
         end
         if (w_hs) begin
            w_data   <= bus.AXI_WDATA;
            w_strb   <= bus.AXI_WSTRB;
            w_have   <= 1'b1;
            wready_q <= 1'b0;
         end else if (w_state == W_IDLE && !w_have) begin
            wready_q <= 1'b1;
         end
         if (wr_fire) begin
            aw_have  <= 1'b0;
            w_have   <= 1'b0;
            bvalid_q <= 1'b1;
            bresp_q  <= wr_resp;
         end
         if (w_state == W_RESP && b_hs) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
         end
      end
   end

   // Write and read share this block so a same-edge collision sees the pre-write word.
   always_ff @(posedge clk) begin
      if (rst_n && wr_fire && wr_resp == RESP_OKAY) begin
         for (int i = 0; i < 4; i++)
            if (w_strb[i])
               mem[aw_addr[ADDR_WIDTH+1:2]][8*i +: 8] <= w_data[8*i +: 8];
      end
      if (r_state == R_MEM)
         ram_q <= mem[ar_addr[ADDR_WIDTH+1:2]];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= R_IDLE;
      else        r_state <= r_state_nxt;
   end

   always_comb begin
      r_state_nxt = r_state;
      case (r_state)
         R_IDLE:  if (ar_hs) r_state_nxt = R_MEM;
         R_MEM:   r_state_nxt = R_DATA;
         R_DATA:  if (r_hs) r_state_nxt = R_IDLE;
         default: r_state_nxt = R_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ar_addr   <= '0;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
         rresp_q   <= RESP_OKAY;
      end else begin
         case (r_state)
            R_IDLE: begin
               if (ar_hs) begin
                  ar_addr   <= bus.AXI_ARADDR;
                  arready_q <= 1'b0;
               end else begin
                  arready_q <= 1'b1;
               end
            end
            R_DATA: begin
               if (!rvalid_q) begin
                  rvalid_q <= 1'b1;
                  rresp_q  <= rd_resp;
                  rdata_q  <= (rd_resp == RESP_OKAY) ? ram_q : '0;
               end else if (bus.AXI_RREADY) begin
                  rvalid_q  <= 1'b0;
                  arready_q <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   logic unused_bits;
   assign unused_bits = ^{bus.AXI_AWPROT, bus.AXI_ARPROT, aw_addr[1:0], ar_addr[1:0]};

endmodule

// File: tb/tb_axi_lite_dmem_slave.sv
// Directed self-checking bench for axi_lite_dmem_slave (honours DMEM_MISALIGN_CHECK_EN).
module tb_axi_lite_dmem_slave;
   localparam int AW = 16;

   logic clk;
   logic rst_n;
   int   tests_run    = 0;
   int   tests_failed = 0;

   axi_lite_dmem_slave_if bus();

   axi_lite_dmem_slave #(.ADDR_WIDTH(AW)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
      bit aw_done = 0, w_done = 0, aw_now, w_now;
      int n = 0;
      bus.AXI_AWVALID = 1; bus.AXI_AWADDR = a;
      bus.AXI_WVALID  = 1; bus.AXI_WDATA  = d; bus.AXI_WSTRB = s;
      bus.AXI_BREADY  = 1;
      while (!(aw_done && w_done) && n < 20) begin
         aw_now = bus.AXI_AWVALID && bus.AXI_AWREADY;
         w_now  = bus.AXI_WVALID && bus.AXI_WREADY;
         tick();
         if (aw_now) begin bus.AXI_AWVALID = 0; aw_done = 1; end
         if (w_now)  begin bus.AXI_WVALID = 0;  w_done = 1;  end
         n++;
      end
      n = 0;
      while (!bus.AXI_BVALID && n < 20) begin tick(); n++; end
      if (!bus.AXI_BVALID) begin
         tests_run++; tests_failed++;
         $display("FAIL write_timeout addr=%h: no BVALID, required BVALID=1", a);
      end
      resp = bus.AXI_BRESP;
      tick();
      bus.AXI_AWVALID = 0; bus.AXI_WVALID = 0;
   endtask

   task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
      int n = 0;
      bit hs;
      bus.AXI_ARVALID = 1; bus.AXI_ARADDR = a; bus.AXI_RREADY = 1;
      hs = 0;
      while (!hs && n < 20) begin
         hs = bus.AXI_ARREADY;
         tick();
         n++;
      end
      bus.AXI_ARVALID = 0;
      n = 0;
      while (!bus.AXI_RVALID && n < 20) begin tick(); n++; end
      if (!bus.AXI_RVALID) begin
         tests_run++; tests_failed++;
         $display("FAIL read_timeout addr=%h: no RVALID, required RVALID=1", a);
      end
      d = bus.AXI_RDATA;
      resp = bus.AXI_RRESP;
      tick();
   endtask

   task automatic test_reset();
      rst_n = 0;
      tick(); tick();
      tests_run++;
      if ({bus.AXI_AWREADY, bus.AXI_WREADY, bus.AXI_ARREADY} !== 3'b000) begin
         tests_failed++;
         $display("FAIL reset_readies got %b required 000", {bus.AXI_AWREADY, bus.AXI_WREADY, bus.AXI_ARREADY});
      end
      tests_run++;
      if ({bus.AXI_BVALID, bus.AXI_RVALID, bus.AXI_BRESP, bus.AXI_RRESP, bus.AXI_RDATA} !== 38'd0) begin
         tests_failed++;
         $display("FAIL reset_outputs bvalid=%b rvalid=%b bresp=%b rresp=%b rdata=%h required all 0",
                  bus.AXI_BVALID, bus.AXI_RVALID, bus.AXI_BRESP, bus.AXI_RRESP, bus.AXI_RDATA);
      end
      rst_n = 1;
      tick();
      tests_run++;
      if ({bus.AXI_AWREADY, bus.AXI_WREADY, bus.AXI_ARREADY} !== 3'b111) begin
         tests_failed++;
         $display("FAIL reset_release_readies got %b required 111", {bus.AXI_AWREADY, bus.AXI_WREADY, bus.AXI_ARREADY});
      end
   endtask

   task automatic test_same_cycle();
      bus.AXI_AWVALID = 1; bus.AXI_AWADDR = 32'h10;
      bus.AXI_WVALID  = 1; bus.AXI_WDATA  = 32'hDEADBEEF; bus.AXI_WSTRB = 4'hF;
      bus.AXI_BREADY  = 1;
      tick();
      bus.AXI_AWVALID = 0; bus.AXI_WVALID = 0;
      tests_run++;
      if ({bus.AXI_AWREADY, bus.AXI_WREADY, bus.AXI_BVALID} !== 3'b000) begin
         tests_failed++;
         $display("FAIL same_cycle_hs aw/w/bvalid=%b required 000", {bus.AXI_AWREADY, bus.AXI_WREADY, bus.AXI_BVALID});
      end
      tick();
      tests_run++;
      if (bus.AXI_BVALID !== 1'b1 || bus.AXI_BRESP !== 2'b00) begin
         tests_failed++;
         $display("FAIL same_cycle_b bvalid=%b bresp=%b required 1/00", bus.AXI_BVALID, bus.AXI_BRESP);
      end
      tick();
      tests_run++;
      if ({bus.AXI_BVALID, bus.AXI_AWREADY, bus.AXI_WREADY} !== 3'b011) begin
         tests_failed++;
         $display("FAIL same_cycle_bdone bvalid/awready/wready=%b required 011", {bus.AXI_BVALID, bus.AXI_AWREADY, bus.AXI_WREADY});
      end
      bus.AXI_ARVALID = 1; bus.AXI_ARADDR = 32'h10; bus.AXI_RREADY = 1;
      tick();
      bus.AXI_ARVALID = 0;
      tests_run++;
      if (bus.AXI_ARREADY !== 1'b0 || bus.AXI_RVALID !== 1'b0) begin
         tests_failed++;
         $display("FAIL read_t0 arready=%b rvalid=%b required 0/0", bus.AXI_ARREADY, bus.AXI_RVALID);
      end
      tick();
      tests_run++;
      if (bus.AXI_RVALID !== 1'b0) begin
         tests_failed++;
         $display("FAIL read_t1 rvalid=%b required 0", bus.AXI_RVALID);
      end
      tick();
      tests_run++;
      if (bus.AXI_RVALID !== 1'b1 || bus.AXI_RDATA !== 32'hDEADBEEF || bus.AXI_RRESP !== 2'b00) begin
         tests_failed++;
         $display("FAIL read_t2 rvalid=%b rdata=%h rresp=%b required 1/deadbeef/00",
                  bus.AXI_RVALID, bus.AXI_RDATA, bus.AXI_RRESP);
      end
      tick();
      tests_run++;
      if (bus.AXI_RVALID !== 1'b0 || bus.AXI_ARREADY !== 1'b1) begin
         tests_failed++;
         $display("FAIL read_done rvalid=%b arready=%b required 0/1", bus.AXI_RVALID, bus.AXI_ARREADY);
      end
   endtask

   task automatic test_w_first();
      logic [31:0] d;
      logic [1:0]  r;
      bus.AXI_WVALID = 1; bus.AXI_WDATA = 32'h000000AA; bus.AXI_WSTRB = 4'b0001;
      bus.AXI_BREADY = 1;
      tick();
      bus.AXI_WVALID = 0;
      for (int i = 0; i < 2; i++) begin
         tests_run++;
         if (bus.AXI_WREADY !== 1'b0 || bus.AXI_AWREADY !== 1'b1 || bus.AXI_BVALID !== 1'b0) begin
            tests_failed++;
            $display("FAIL w_first_wait wready=%b awready=%b bvalid=%b required 0/1/0",
                     bus.AXI_WREADY, bus.AXI_AWREADY, bus.AXI_BVALID);
         end
         tick();
      end
      bus.AXI_AWVALID = 1; bus.AXI_AWADDR = 32'h10;
      tick();
      bus.AXI_AWVALID = 0;
      tests_run++;
      if (bus.AXI_BVALID !== 1'b0) begin
         tests_failed++;
         $display("FAIL w_first_early_b bvalid=%b required 0", bus.AXI_BVALID);
      end
      tick();
      tests_run++;
      if (bus.AXI_BVALID !== 1'b1 || bus.AXI_BRESP !== 2'b00) begin
         tests_failed++;
         $display("FAIL w_first_b bvalid=%b bresp=%b required 1/00", bus.AXI_BVALID, bus.AXI_BRESP);
      end
      tick();
      do_read(32'h10, d, r);
      tests_run++;
      if (d !== 32'hDEADBEAA || r !== 2'b00) begin
         tests_failed++;
         $display("FAIL w_first_strobe rdata=%h rresp=%b required deadbeaa/00", d, r);
      end
   endtask

   task automatic test_read_stall();
      logic [1:0] r;
      int n = 0;
      do_write(32'h20, 32'hCAFEF00D, 4'hF, r);
      bus.AXI_ARVALID = 1; bus.AXI_ARADDR = 32'h20; bus.AXI_RREADY = 0;
      tick();
      bus.AXI_ARVALID = 0;
      while (!bus.AXI_RVALID && n < 10) begin tick(); n++; end
      for (int i = 0; i < 5; i++) begin
         tests_run++;
         if (bus.AXI_RVALID !== 1'b1 || bus.AXI_RDATA !== 32'hCAFEF00D || bus.AXI_ARREADY !== 1'b0) begin
            tests_failed++;
            $display("FAIL stall_hold cyc=%0d rvalid=%b rdata=%h arready=%b required 1/cafef00d/0",
                     i, bus.AXI_RVALID, bus.AXI_RDATA, bus.AXI_ARREADY);
         end
         tick();
      end
      bus.AXI_RREADY = 1;
      tick();
      tests_run++;
      if (bus.AXI_ARREADY !== 1'b1 || bus.AXI_RVALID !== 1'b0) begin
         tests_failed++;
         $display("FAIL stall_release arready=%b rvalid=%b required 1/0", bus.AXI_ARREADY, bus.AXI_RVALID);
      end
   endtask

   task automatic test_out_of_range();
      logic [31:0] oor, d;
      logic [1:0]  r;
      oor = 32'h1 << (AW + 2);
      do_write(32'h0, 32'h01020304, 4'hF, r);
      do_write(oor, 32'hFFFFFFFF, 4'hF, r);
      tests_run++;
      if (r !== 2'b11) begin
         tests_failed++;
         $display("FAIL oor_bresp got %b required 11", r);
      end
      do_read(oor, d, r);
      tests_run++;
      if (r !== 2'b11 || d !== 32'h0) begin
         tests_failed++;
         $display("FAIL oor_read rresp=%b rdata=%h required 11/00000000", r, d);
      end
      do_write(32'h0, 32'hFFFFFFFF, 4'b0000, r);
      tests_run++;
      if (r !== 2'b00) begin
         tests_failed++;
         $display("FAIL zero_strb_bresp got %b required 00", r);
      end
      do_read(32'h0, d, r);
      tests_run++;
      if (d !== 32'h01020304 || r !== 2'b00) begin
         tests_failed++;
         $display("FAIL word0_unchanged rdata=%h rresp=%b required 01020304/00", d, r);
      end
   endtask

   task automatic test_collision();
      logic [31:0] d;
      logic [1:0]  r;
      do_write(32'h30, 32'h11111111, 4'hF, r);
      bus.AXI_AWVALID = 1; bus.AXI_AWADDR = 32'h30;
      bus.AXI_WVALID  = 1; bus.AXI_WDATA  = 32'h12345678; bus.AXI_WSTRB = 4'hF;
      bus.AXI_ARVALID = 1; bus.AXI_ARADDR = 32'h30;
      bus.AXI_BREADY  = 1; bus.AXI_RREADY = 1;
      tick();
      bus.AXI_AWVALID = 0; bus.AXI_WVALID = 0; bus.AXI_ARVALID = 0;
      tick();
      tests_run++;
      if (bus.AXI_BVALID !== 1'b1) begin
         tests_failed++;
         $display("FAIL collide_b bvalid=%b required 1", bus.AXI_BVALID);
      end
      tick();
      tests_run++;
      if (bus.AXI_RVALID !== 1'b1 || bus.AXI_RDATA !== 32'h11111111) begin
         tests_failed++;
         $display("FAIL collide_read_first rvalid=%b rdata=%h required 1/11111111", bus.AXI_RVALID, bus.AXI_RDATA);
      end
      tick();
      do_read(32'h30, d, r);
      tests_run++;
      if (d !== 32'h12345678) begin
         tests_failed++;
         $display("FAIL collide_after rdata=%h required 12345678", d);
      end
   endtask

   task automatic test_reset_midflight();
      logic [31:0] d;
      logic [1:0]  r;
      bus.AXI_AWVALID = 1; bus.AXI_AWADDR = 32'h40;
      bus.AXI_WVALID  = 1; bus.AXI_WDATA  = 32'h55555555; bus.AXI_WSTRB = 4'hF;
      bus.AXI_BREADY  = 0; bus.AXI_RREADY = 0;
      tick();
      bus.AXI_AWVALID = 0; bus.AXI_WVALID = 0;
      bus.AXI_ARVALID = 1; bus.AXI_ARADDR = 32'h10;
      tick();
      bus.AXI_ARVALID = 0;
      tests_run++;
      if (bus.AXI_BVALID !== 1'b1 || bus.AXI_ARREADY !== 1'b0) begin
         tests_failed++;
         $display("FAIL midflight_setup bvalid=%b arready=%b required 1/0", bus.AXI_BVALID, bus.AXI_ARREADY);
      end
      rst_n = 0;
      tick();
      tests_run++;
      if ({bus.AXI_BVALID, bus.AXI_RVALID, bus.AXI_AWREADY, bus.AXI_WREADY, bus.AXI_ARREADY} !== 5'b0) begin
         tests_failed++;
         $display("FAIL midflight_reset bv/rv/awr/wr/arr=%b required 00000",
                  {bus.AXI_BVALID, bus.AXI_RVALID, bus.AXI_AWREADY, bus.AXI_WREADY, bus.AXI_ARREADY});
      end
      rst_n = 1;
      bus.AXI_BREADY = 1; bus.AXI_RREADY = 1;
      tick();
      tick(); tick();
      tests_run++;
      if ({bus.AXI_BVALID, bus.AXI_RVALID, bus.AXI_AWREADY, bus.AXI_WREADY, bus.AXI_ARREADY} !== 5'b00111) begin
         tests_failed++;
         $display("FAIL midflight_after bv/rv/awr/wr/arr=%b required 00111",
                  {bus.AXI_BVALID, bus.AXI_RVALID, bus.AXI_AWREADY, bus.AXI_WREADY, bus.AXI_ARREADY});
      end
      do_read(32'h31, d, r);
`ifdef DMEM_MISALIGN_CHECK_EN
      tests_run++;
      if (r !== 2'b10 || d !== 32'h0) begin
         tests_failed++;
         $display("FAIL misalign_read rresp=%b rdata=%h required 10/00000000", r, d);
      end
`else
      tests_run++;
      if (r !== 2'b00 || d !== 32'h12345678) begin
         tests_failed++;
         $display("FAIL misalign_ignored rresp=%b rdata=%h required 00/12345678", r, d);
      end
`endif
   endtask

   initial begin
      rst_n = 0;
      bus.AXI_AWVALID = 0; bus.AXI_AWADDR = 0; bus.AXI_AWPROT = 0;
      bus.AXI_WVALID  = 0; bus.AXI_WDATA  = 0; bus.AXI_WSTRB  = 0;
      bus.AXI_BREADY  = 0;
      bus.AXI_ARVALID = 0; bus.AXI_ARADDR = 0; bus.AXI_ARPROT = 0;
      bus.AXI_RREADY  = 0;
      test_reset();
      test_same_cycle();
      test_w_first();
      test_read_stall();
      test_out_of_range();
      test_collision();
      test_reset_midflight();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
